// File: rtl/mant_div_pkg.sv
// Shared types for the mantissa divider: FSM states, default width, result flags.
// Sticky output is present only when MANT_DIV_STICKY_EN is defined.
package mant_div_pkg;

   localparam int MANT_W = 24;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic div_zero;
      logic overflow;
   } flags_t;

endpackage

// File: rtl/mant_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
// Zero latency; no flow control.
module div_step #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] i_p,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_p,
   output logic             o_qbit
);

   logic [WIDTH:0] w_t;

   assign w_t    = {i_p, i_bit};
   assign o_qbit = (w_t >= {1'b0, i_divisor});
   // When the subtract happens the result is below divisor, so the low WIDTH bits are exact.
   assign o_p    = o_qbit ? (w_t[WIDTH-1:0] - i_divisor) : w_t[WIDTH-1:0];

endmodule

// File: rtl/mant_divider.sv
// Radix-2 restoring divider, 2W/W -> W quotient+remainder; WIDTH+1 clocks per op, 1 clock for div-by-zero/overflow.
// Accepts only in IDLE; result held in DONE until out_ready. Sticky output guarded by MANT_DIV_STICKY_EN.
module mant_divider
   import mant_div_pkg::*;
#(
   parameter int WIDTH = MANT_W,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_zero,
   output logic               overflow
`ifdef MANT_DIV_STICKY_EN
   ,
   output logic               sticky
`endif
);

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   flags_t           r_flags;
   logic [WIDTH-1:0] w_p;
   logic             w_qbit;
`ifdef MANT_DIV_STICKY_EN
   logic             r_sticky;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_p       (r_p),
      .i_bit     (r_q[WIDTH-1]),
      .i_divisor (r_divisor),
      .o_p       (w_p),
      .o_qbit    (w_qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_p         <= '0;
         r_q         <= '0;
         r_divisor   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_flags     <= '0;
`ifdef MANT_DIV_STICKY_EN
         r_sticky    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_flags <= '0;
`ifdef MANT_DIV_STICKY_EN
                  r_sticky <= 1'b0;
`endif
                  if (divisor == '0) begin
                     r_state          <= S_DONE;
                     r_flags.div_zero <= 1'b1;
                     r_quotient       <= '1;
                     r_remainder      <= dividend[WIDTH-1:0];
                  end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                     r_state          <= S_DONE;
                     r_flags.overflow <= 1'b1;
                     r_quotient       <= '1;
                     r_remainder      <= '0;
                  end else begin
                     r_state   <= S_RUN;
                     r_p       <= dividend[2*WIDTH-1:WIDTH];
                     r_q       <= dividend[WIDTH-1:0];
                     r_divisor <= divisor;
                     r_cnt     <= CNT_W'(WIDTH);
                  end
               end
            end
            S_RUN: begin
               // Extra cycle at cnt==0 registers the result, giving WIDTH+1 clocks total.
               if (r_cnt != '0) begin
                  r_p   <= w_p;
                  r_q   <= {r_q[WIDTH-2:0], w_qbit};
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state     <= S_DONE;
                  r_quotient  <= r_q;
                  r_remainder <= r_p;
`ifdef MANT_DIV_STICKY_EN
                  r_sticky    <= |r_p;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_flags.div_zero;
   assign overflow  = r_flags.overflow;
`ifdef MANT_DIV_STICKY_EN
   assign sticky    = r_sticky;
`endif

endmodule

// File: tb/tb_mant_divider.sv
// Directed bench for mant_divider with hand-computed quotients, remainders, flags and latencies.
// Sticky checks are compiled in when MANT_DIV_STICKY_EN is defined.
module tb_mant_divider;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [47:0] dividend = '0;
   logic [23:0] divisor = '0;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] quotient;
   logic [23:0] remainder;
   logic        div_zero;
   logic        overflow;
`ifdef MANT_DIV_STICKY_EN
   logic        sticky;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   mant_divider #(.WIDTH(24), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .overflow  (overflow)
`ifdef MANT_DIV_STICKY_EN
      ,
      .sticky    (sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge with the divider idle; returns edges from accept to out_valid.
   task automatic issue(input logic [47:0] a, input logic [23:0] b, output int l);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = 48'h5A5A5A_A5A5A5;
      divisor  = 24'd3;
      l = 0;
      while (!out_valid && l < 200) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic retire;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_div_zero", div_zero, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 100 / 7 = 14 r 2
      issue(48'h64, 24'd7, lat);
      check("c1_latency", lat, 25);
      check("c1_quotient", quotient, 14);
      check("c1_remainder", remainder, 2);
      check("c1_div_zero", div_zero, 0);
      check("c1_overflow", overflow, 0);
`ifdef MANT_DIV_STICKY_EN
      check("c1_sticky", sticky, 1);
`endif

      // Hold result with a new request pending; it must be ignored.
      in_valid = 1'b1;
      dividend = 48'h3E8;
      divisor  = 24'd3;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("c5_hold_valid", out_valid, 1);
         check("c5_hold_in_ready", in_ready, 0);
         check("c5_hold_quotient", quotient, 14);
         check("c5_hold_remainder", remainder, 2);
      end
      in_valid = 1'b0;
      retire();
      check("c5_retire_in_ready", in_ready, 1);
      check("c5_retire_out_valid", out_valid, 0);
      check("c5_no_new_op", quotient, 14);

      // FFFFFF * FFFFFF = FFFFFE000001
      issue(48'hFFFFFE_000001, 24'hFFFFFF, lat);
      check("c2_latency", lat, 25);
      check("c2_quotient", quotient, 24'hFFFFFF);
      check("c2_remainder", remainder, 0);
      check("c2_overflow", overflow, 0);
`ifdef MANT_DIV_STICKY_EN
      check("c2_sticky", sticky, 0);
`endif
      retire();

      issue(48'h123456_ABCDEF, 24'd0, lat);
      check("c3_latency", lat, 0);
      check("c3_div_zero", div_zero, 1);
      check("c3_overflow", overflow, 0);
      check("c3_quotient", quotient, 24'hFFFFFF);
      check("c3_remainder", remainder, 24'hABCDEF);
`ifdef MANT_DIV_STICKY_EN
      check("c3_sticky", sticky, 0);
`endif
      retire();

      // High half equals divisor: the overflow boundary
      issue(48'h000010_000000, 24'h10, lat);
      check("c4_latency", lat, 0);
      check("c4_overflow", overflow, 1);
      check("c4_div_zero", div_zero, 0);
      check("c4_quotient", quotient, 24'hFFFFFF);
      check("c4_remainder", remainder, 0);
      retire();

      // Flags clear on the next accepted op; 1000 / 7 = 142 r 6
      issue(48'h3E8, 24'd7, lat);
      check("c7_latency", lat, 25);
      check("c7_quotient", quotient, 142);
      check("c7_remainder", remainder, 6);
      check("c7_overflow", overflow, 0);
      check("c7_div_zero", div_zero, 0);
      retire();

      // Reset in the middle of a run
      in_valid = 1'b1;
      dividend = 48'h64;
      divisor  = 24'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("c6_busy_before_rst", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("c6_rst_out_valid", out_valid, 0);
      check("c6_rst_in_ready", in_ready, 1);
      check("c6_rst_quotient", quotient, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(48'h64, 24'd7, lat);
      check("c6_latency", lat, 25);
      check("c6_quotient", quotient, 14);
      check("c6_remainder", remainder, 2);
      retire();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
